// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

    localparam int unsigned SUB_W_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // 2:1 mux primitive: sel=0 -> d0, sel=1 -> d1.
    function automatic logic mux2(input logic sel, input logic d0, input logic d1);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// Combinational full-subtractor bit cell (a - b - c), built from 2:1 muxes.
module fs_bit_cell
    import sub_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic diff_o,
    output logic borrow_o
);

    logic axb;

    assign axb = mux2(a_i, b_i, ~b_i);
    assign diff_o = mux2(c_i, axb, ~axb);
    // a=0: borrow when b or c set; a=1: borrow only when both set.
    assign borrow_o = mux2(a_i, b_i | c_i, b_i & c_i);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared bit cell, LSB first, registered borrow chain.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    if (WIDTH < 1 || WIDTH > SUB_W_MAX) begin : g_width_chk
        $error("serial_sub_ctrl: WIDTH out of range");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-1:0]   diff_sr_q;
    logic [WIDTH-1:0]   diff_sr_d;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               cell_d;
    logic               cell_bo;
    logic               last_bit;

    fs_bit_cell u_cell (
        .a_i      (a_sr_q[0]),
        .b_i      (b_sr_q[0]),
        .c_i      (borrow_q),
        .diff_o   (cell_d),
        .borrow_o (cell_bo)
    );

    // New difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign diff_sr_d = (diff_sr_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_sr_q   <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q    <= RUN;
                        a_sr_q     <= a;
                        b_sr_q     <= b;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        diff_sr_q  <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr_q    <= a_sr_q >> 1;
                    b_sr_q    <= b_sr_q >> 1;
                    borrow_q  <= cell_bo;
                    cnt_q     <= cnt_d;
                    diff_sr_q <= diff_sr_d;
                    if (last_bit) begin
                        state_q     <= DONE;
                        diff_q      <= diff_sr_d;
                        bout_q      <= cell_bo;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8, 4 and 1.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8 instance
    logic       iv8 = 0, ir8, ov8, or8 = 1, bi8 = 0, bo8, busy8;
    logic [7:0] a8 = 0, b8 = 0, d8;
    logic [8:0] q8[$];
    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bi8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .busy(busy8));

    // WIDTH=4 instance
    logic       iv4 = 0, ir4, ov4, or4 = 1, bi4 = 0, bo4, busy4;
    logic [3:0] a4 = 0, b4 = 0, d4;
    logic [4:0] q4[$];
    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bi4),
        .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4), .busy(busy4));

    // WIDTH=1 instance
    logic       iv1 = 0, ir1, ov1, or1 = 1, bi1 = 0, bo1, busy1;
    logic       a1 = 0, b1 = 0, d1;
    logic [1:0] q1[$];
    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .bin(bi1),
        .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1), .busy(busy1));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation on every output handshake.
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) chk("sb8_unexpected", 1, 0);
            else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("sb8_result", int'({bo8, d8}), int'(e));
            end
        end
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) chk("sb4_unexpected", 1, 0);
            else begin
                logic [4:0] e;
                e = q4.pop_front();
                chk("sb4_result", int'({bo4, d4}), int'(e));
            end
        end
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
            else begin
                logic [1:0] e;
                e = q1.pop_front();
                chk("sb1_result", int'({bo1, d1}), int'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input bit push, input logic [8:0] exp);
        int n = 0;
        while (!ir8 && n < 100) begin tick(); n++; end
        if (!ir8) chk("ir8_timeout", 0, 1);
        iv8 = 1; a8 = a; b8 = b; bi8 = bi;
        if (push) q8.push_back(exp);
        tick();
        iv8 = 0;
    endtask

    // Counts edges from the accepting edge until out_valid; flags in_ready seen high meanwhile.
    task automatic wait_done8(output int lat, output bit ir_seen);
        lat = 0;
        ir_seen = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (ir8) ir_seen = 1;
            if (ov8) begin lat = k; break; end
        end
        if (!ov8) chk("ov8_timeout", 0, 1);
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (n < 60 && ((which == 8 && q8.size() != 0) || (which == 4 && q4.size() != 0)
                          || (which == 1 && q1.size() != 0))) begin
            tick();
            n++;
        end
        if (n >= 60) chk("drain_timeout", which, 0);
    endtask

    initial begin
        int  lat;
        bit  irs;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", int'(ir8), 0);
        chk("rst_out_valid", int'(ov8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_diff_bout", int'({bo8, d8}), 0);
        rst = 0;
        tick();
        chk("in_ready_after_rst", int'(ir8), 1);

        // 1: 200-55
        issue8(8'd200, 8'd55, 1'b0, 1, {1'b0, 8'd145});
        chk("t1_busy", int'(busy8), 1);
        wait_done8(lat, irs);
        chk("t1_latency", lat, 8);
        chk("t1_in_ready_low", int'(irs), 0);
        drain(8);

        // 2: 5-10 wraps with borrow out
        issue8(8'd5, 8'd10, 1'b0, 1, {1'b1, 8'd251});
        wait_done8(lat, irs);
        drain(8);

        // 3: 0-0-1 ripples a borrow through every bit
        issue8(8'd0, 8'd0, 1'b1, 1, {1'b1, 8'd255});
        wait_done8(lat, irs);
        drain(8);

        // 4: backpressure in DONE with a pending request
        issue8(8'd9, 8'd3, 1'b0, 1, {1'b0, 8'd6});
        wait_done8(lat, irs);
        or8 = 0;
        iv8 = 1; a8 = 8'd1; b8 = 8'd1; bi8 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_ov_held", int'(ov8), 1);
            chk("t4_ir_low", int'(ir8), 0);
            chk("t4_diff_held", int'({bo8, d8}), 6);
        end
        chk("t4_not_popped", q8.size(), 1);
        q8.push_back({1'b0, 8'd0});
        or8 = 1;
        tick();
        chk("t4_idle_ready", int'(ir8), 1);
        chk("t4_idle_ov", int'(ov8), 0);
        tick();
        chk("t4_second_taken", int'(busy8), 1);
        iv8 = 0;
        wait_done8(lat, irs);
        chk("t4_latency", lat, 8);
        drain(8);

        // 5: reset mid-RUN discards the op and clears outputs
        issue8(8'd5, 8'd10, 1'b0, 1, {1'b1, 8'd251});
        wait_done8(lat, irs);
        drain(8);
        issue8(8'd77, 8'd3, 1'b0, 0, '0);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("t5_ov", int'(ov8), 0);
        chk("t5_busy", int'(busy8), 0);
        chk("t5_diff_bout", int'({bo8, d8}), 0);
        repeat (12) tick();
        chk("t5_no_result", int'(ov8), 0);
        chk("t5_ready", int'(ir8), 1);
        issue8(8'd100, 8'd1, 1'b0, 1, {1'b0, 8'd99});
        wait_done8(lat, irs);
        chk("t5_latency", lat, 8);
        drain(8);

        // 6: exhaustive WIDTH=4 and WIDTH=1 against (a-b-bin)
        for (int ai = 0; ai < 16; ai++)
            for (int bb = 0; bb < 16; bb++)
                for (int ci = 0; ci < 2; ci++) begin
                    int n = 0;
                    while (!ir4 && n < 50) begin tick(); n++; end
                    iv4 = 1; a4 = 4'(ai); b4 = 4'(bb); bi4 = 1'(ci);
                    q4.push_back({1'((ai < bb + ci) ? 1 : 0), 4'(ai - bb - ci)});
                    tick();
                    iv4 = 0;
                    drain(4);
                end
        for (int ai = 0; ai < 2; ai++)
            for (int bb = 0; bb < 2; bb++)
                for (int ci = 0; ci < 2; ci++) begin
                    int n = 0;
                    while (!ir1 && n < 50) begin tick(); n++; end
                    iv1 = 1; a1 = 1'(ai); b1 = 1'(bb); bi1 = 1'(ci);
                    q1.push_back({1'((ai < bb + ci) ? 1 : 0), 1'(ai - bb - ci)});
                    tick();
                    iv1 = 0;
                    drain(1);
                end

        repeat (3) tick();
        chk("final_q8_empty", q8.size(), 0);
        chk("final_q4_empty", q4.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
